p2s_rr_scheduler: RTL and testbench
===================================

# p2s_rr_scheduler

Round-robin scheduler that shares one 4-bit parallel-to-serial shifter among several requesters. Each requester presents a parallel word with a level request. The scheduler grants one requester at a time and acknowledges it. It then serializes the granted word LSB first, tagging each output bit with the source index. Downstream serial consumers use `src_o` and `sof_o` to demultiplex the stream.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 4: word width in bits, 2..16.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_i` in `NUM_REQ`: per-requester level request.
- `data_i` in `NUM_REQ*DATA_W`: requester k's word is `data_i[k*DATA_W +: DATA_W]`.
- `ack_o` out `NUM_REQ`: one-hot, single-cycle pulse; the word is accepted in that cycle.
- `serial_o` out 1: current serial bit; 0 when `valid_o`=0.
- `valid_o` out 1: `serial_o` carries a data bit.
- `sof_o` out 1: first bit (bit 0) of a word.
- `src_o` out `$clog2(NUM_REQ)`: index of the requester whose bit is on `serial_o`; 0 when idle.
- `empty_o` out 1: shifter holds no pending bits (equals ~`valid_o`).

## Operation
- States:
  - IDLE: shifter empty.
  - SHIFT: `count` bits remain, `count` ranges 1..`DATA_W`.
- Accept window: the state is IDLE, or the state is SHIFT with `count`==1 (last bit).
  - A word can be accepted only in an accept window and only when `reset`=0.
  - This gives gapless back-to-back words.
- Arbitration happens in the accept window when `|req_i`:
  - The round-robin search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - The winner w gets `ack_o[w]`=1 combinationally in the same cycle.
  - On that posedge: shift register <= word w, `src` <= w, `count` <= `DATA_W`, `last_grant` <= w, state <= SHIFT.
- No request in an accept window:
  - From SHIFT with `count`==1, go to IDLE after the last bit.
  - In IDLE, stay in IDLE.
- In SHIFT without accept: shift right by 1 (zero fill), `count` decrements.
- Requester rules:
  - Hold `req_i` and keep `data_i` stable until ack.
  - Dropping `req_i` before ack is a legal withdrawal; nothing is sent.
  - After ack, a requester may re-request in the next cycle. It then ranks behind all other active requesters.
- `ack_o` is never asserted outside an accept window, and never for a requester with `req_i`=0.
- Reset:
  - `last_grant` <= `NUM_REQ-1`, so requester 0 has priority first.
  - State <= IDLE, `count` <= 0, shift register <= 0.
- Reset mid-word: the in-flight word is discarded, not retransmitted, and no ack is issued during reset.

## Timing
- Reset values: `serial_o`=0, `valid_o`=0, `sof_o`=0, `src_o`=0, `ack_o`=0, `empty_o`=1.
- All outputs except `ack_o` are registered state or a direct decode of registered state.
- Grant at cycle T (`ack_o` high): bit i of the word appears at T+1+i, i=0..`DATA_W-1`.
  - `valid_o`=1 and `src_o`=w over T+1..T+`DATA_W`.
  - `sof_o`=1 only at T+1.
- Latency from req rising (IDLE, no contention) to first bit: 1 cycle after ack, with ack in the same cycle as req.
- Throughput: one word per `DATA_W` cycles under continuous requests; no idle cycle between words.
- Simultaneous last bit of word A and grant of word B: bit `DATA_W-1` of A is output in that cycle, and B's `sof_o` appears in the next cycle.
- Reset asserted at cycle R: all outputs take reset values from R+1, and `ack_o` is forced 0 at R.

## Structure
- Shared package `p2s_pkg`:
  - `state_t` enum {IDLE, SHIFT}.
  - `P2S_DATA_W`=4 and `P2S_NUM_REQ`=4 default constants.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `clk`, `reset`, `req`, `en`; outputs one-hot `gnt` and `gnt_idx`.
  - `gnt` is combinational from `req`, the pointer and `en`.
  - It owns the `last_grant` pointer, updated on `en & |req`.
- Top-level `p2s_rr_scheduler` holds the FSM, `count`, shift and `src` registers, and the output decode.

## Test plan
- Reset check:
  - Stimulus: hold `reset` 3 cycles with `req_i`=4'hF.
  - Required: `ack_o`=0, `valid_o`=0, `empty_o`=1 and `serial_o`=0 throughout.
- Single word:
  - Stimulus: `req_i`=4'b0100, word2=4'hB, from IDLE.
  - Required: `ack_o`=4'b0100 the same cycle; `serial_o` = 1,1,0,1 over the next 4 cycles; `src_o`=2; `sof_o` on the first bit; IDLE afterwards.
- Round-robin fairness:
  - Stimulus: `req_i`=4'hF held continuously, with each requester re-requesting right after its ack.
  - Required: ack order 0,1,2,3,0,1,…; one ack every 4 cycles; `valid_o` continuously 1 with no gaps.
- Skip and wrap:
  - Stimulus: after a grant to 3, `req_i`=4'b0011.
  - Required: 0 granted, then 1; `last_grant` wraps correctly.
- Withdrawal:
  - Stimulus: requester 1 raises req during word 0, then drops it before the accept window.
  - Required: no `ack_o[1]`, and the scheduler goes IDLE after word 0.
- Reset mid-word:
  - Stimulus: assert `reset` after bit 1 of word 4'h6 from requester 0.
  - Required: outputs return to reset values the next cycle; with req still high after release, 0 is re-granted fresh and its `sof_o` bit is bit 0.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and default sizes for the round-robin parallel-to-serial scheduler.
package p2s_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int P2S_DATA_W  = 4;
  localparam int P2S_NUM_REQ = 4;
endpackage

// File: rtl/p2s_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, pointer advances on a taken grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] last_q;
  logic [IW-1:0] cand;
  logic          found;
  int            pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    pos     = 0;
    // Offsets 1..N visit every requester once, ending at the last winner itself.
    for (int off = 1; off <= N; off++) begin
      pos = int'(last_q) + off;
      if (pos >= N) pos = pos - N;
      cand = pos[IW-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IW'(N - 1);
    end else if (en && found) begin
      last_q <= gnt_idx;
    end
  end
endmodule

// File: rtl/p2s_rr_scheduler.sv
// Shares one LSB-first shifter among NUM_REQ requesters; each bit is tagged with its source index.
module p2s_rr_scheduler
  import p2s_pkg::*;
#(
  parameter int NUM_REQ = P2S_NUM_REQ,
  parameter int DATA_W  = P2S_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*DATA_W-1:0]  data_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic                       serial_o,
  output logic                       valid_o,
  output logic                       sof_o,
  output logic [$clog2(NUM_REQ)-1:0] src_o,
  output logic                       empty_o
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [SW-1:0]       src_q, src_d;
  logic                accept;
  logic                grant_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [SW-1:0]       gnt_idx;
  logic [DATA_W-1:0]   word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign word[gi] = data_i[gi*DATA_W +: DATA_W];
  end

  // Accepting on the last bit lets the next word follow with no idle cycle.
  assign accept   = (state_q == IDLE) || (count_q == CNT_ONE);
  assign grant_en = accept && !reset;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_i),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ack_o = gnt;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    src_d   = src_q;
    if (grant_en && |req_i) begin
      state_d = SHIFT;
      count_d = CNT_FULL;
      shift_d = word[gnt_idx];
      src_d   = gnt_idx;
    end else if (state_q == SHIFT) begin
      if (count_q == CNT_ONE) begin
        state_d = IDLE;
        count_d = '0;
        shift_d = '0;
        src_d   = '0;
      end else begin
        shift_d = shift_q >> 1;
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      shift_q <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      src_q   <= src_d;
    end
  end

  assign valid_o  = (state_q == SHIFT);
  assign serial_o = valid_o && shift_q[0];
  assign sof_o    = valid_o && (count_q == CNT_FULL);
  assign src_o    = valid_o ? src_q : '0;
  assign empty_o  = !valid_o;
endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Directed bench: stimulus pushes expected serial bits per grant, a negedge monitor pops and compares.
module tb_p2s_rr_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_i = 4'b0000;
  logic [15:0] data_i;
  logic [3:0]  ack_o;
  logic        serial_o, valid_o, sof_o, empty_o;
  logic [1:0]  src_o;

  logic [3:0]  words [4];
  logic [4:0]  exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          step = 0;
  bit          running = 1'b1;

  p2s_rr_scheduler #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .serial_o (serial_o),
    .valid_o  (valid_o),
    .sof_o    (sof_o),
    .src_o    (src_o),
    .empty_o  (empty_o)
  );

  always #5 clk = ~clk;

  initial begin
    words[0] = 4'h6;
    words[1] = 4'h9;
    words[2] = 4'hB;
    words[3] = 4'h5;
  end
  assign data_i = {words[3], words[2], words[1], words[0]};

  // Each entry: {serial, sof, empty, src}
  always @(negedge clk) begin
    if (running) begin
      if (valid_o) begin
        logic [4:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_bit step=%0d got serial=%b sof=%b src=%0d want no valid bit",
                   step, serial_o, sof_o, src_o);
        end else begin
          e = exp_q.pop_front();
          if ({serial_o, sof_o, empty_o, src_o} !== e) begin
            n_fail++;
            $display("FAIL serial_bit step=%0d got {ser,sof,empty,src}=%b want %b",
                     step, {serial_o, sof_o, empty_o, src_o}, e);
          end
        end
      end else begin
        n_checks++;
        if ({serial_o, sof_o, empty_o, src_o} !== 5'b00100) begin
          n_fail++;
          $display("FAIL idle_outputs step=%0d got {ser,sof,empty,src}=%b want 00100",
                   step, {serial_o, sof_o, empty_o, src_o});
        end
      end
    end
  end

  task automatic cyc(input logic [3:0] rq, input logic rst, input logic [3:0] exp_ack,
                     input logic exp_valid, input bit flush);
    int w;
    @(posedge clk);
    if (flush) exp_q.delete();
    #1;
    req_i = rq;
    reset = rst;
    @(negedge clk);
    n_checks++;
    if (ack_o !== exp_ack) begin
      n_fail++;
      $display("FAIL ack step=%0d got=%b want=%b", step, ack_o, exp_ack);
    end
    n_checks++;
    if (valid_o !== exp_valid) begin
      n_fail++;
      $display("FAIL valid step=%0d got=%b want=%b", step, valid_o, exp_valid);
    end
    if (exp_ack != 4'b0000) begin
      w = 0;
      for (int k = 0; k < 4; k++) if (exp_ack[k]) w = k;
      for (int i = 0; i < 4; i++)
        exp_q.push_back({words[w][i], (i == 0), 1'b0, 2'(w)});
      $display("step %0d: grant requester %0d word %h", step, w, words[w]);
    end
    step++;
  endtask

  initial begin
    // Reset held with all requests active
    for (int i = 0; i < 3; i++) cyc(4'hF, 1'b1, 4'b0000, 1'b0, 1'b0);

    // Single word from requester 2 (0xB -> 1,1,0,1)
    cyc(4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Reset the pointer, then continuous requests: 0,1,2,3,0,1,2,3 gapless
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(4'hF, 1'b0, 4'b0001, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      for (int i = 0; i < 3; i++) cyc(4'hF, 1'b0, 4'b0000, 1'b1, 1'b0);
      cyc(4'hF, 1'b0, 4'(1 << (k % 4)), 1'b1, 1'b0);
    end

    // After grant to 3, only 0 and 1 request: 0 then 1
    for (int i = 0; i < 3; i++) cyc(4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Withdrawal: requester 1 requests during word 0, drops before the window
    cyc(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Reset after bit 1 of word 0x6, request held; fresh re-grant afterwards
    cyc(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    running = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_bits got=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
